// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the LIFO stack controller.
//   - OP_* : operation codes, decoded from {push, pop}
//   - depth(): number of entries for a given log2 depth
// -----------------------------------------------------------------------------
package stack_pkg;

    // Operation encoding, bit 1 = push strobe, bit 0 = pop strobe.
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_RPL  = 2'b11;

    // Number of stack entries for a log2 depth of h.
    function automatic int depth(input int h);
        return 1 << h;
    endfunction

endpackage : stack_pkg

// File: rtl/stack_regfile.sv
// -----------------------------------------------------------------------------
// stack_regfile
// W x 2**H register array backing the LIFO stack. One synchronous write port
// and one asynchronous (combinational) read port. The array has no reset; the
// controller never exposes an entry that has not been written since the
// stack last emptied.
//
// Ports:
//   clk        in   clock, writes on the rising edge
//   wr_en      in   write strobe
//   wr_addr    in   H   write address
//   wr_data    in   W   write data
//   rd_addr    in   H   read address
//   rd_data    out  W   array contents at rd_addr (combinational)
// -----------------------------------------------------------------------------
module stack_regfile
    import stack_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 3
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [H-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [H-1:0] rd_addr,
    output logic [W-1:0] rd_data
);

    localparam int DEPTH = depth(H);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : stack_regfile

// File: rtl/lifo_stack_ctrl.sv
// -----------------------------------------------------------------------------
// lifo_stack_ctrl
// Parametrised upward-growing LIFO stack used to save and restore context
// words. Supports push, pop, simultaneous push+pop (replace when non-empty,
// bypass when empty), synchronous flush, occupancy reporting and sticky
// overflow/underflow flags.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   clear_n      in   asynchronous active-low reset
//   clear        in   synchronous flush, overrides push/pop
//   push         in   push data_in this cycle
//   pop          in   pop top of stack this cycle
//   data_in      in   W     word to push
//   err_clr      in   clear sticky error flags (a same-cycle error wins)
//   data_out     out  W     registered popped word, held until next pop
//   dout_valid   out  one-cycle pulse the cycle after a successful pop
//   top          out  W     combinational top of stack, 0 when empty
//   count        out  H+1   number of stored entries, 0..2**H
//   empty        out  count == 0
//   full         out  count == 2**H
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky, push-only attempted while full
//   underflow    out  sticky, pop-only attempted while empty
// -----------------------------------------------------------------------------
module lifo_stack_ctrl
    import stack_pkg::*;
#(
    parameter int W        = 8,
    parameter int H        = 3,
    parameter int AF_LEVEL = depth(H) - 1
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    input  logic         err_clr,
    output logic [W-1:0] data_out,
    output logic         dout_valid,
    output logic [W-1:0] top,
    output logic [H:0]   count,
    output logic         empty,
    output logic         full,
    output logic         almost_full,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH  = depth(H);
    localparam logic [H:0] D_CNT  = (H+1)'(DEPTH);
    localparam logic [H:0] AF_CNT = (H+1)'(AF_LEVEL);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [H:0]   count_q, count_d;
    logic [W-1:0] dout_q, dout_d;
    logic         dv_q, dv_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    // Register file interface
    logic         wr_en;
    logic [H-1:0] wr_addr;
    logic [H-1:0] top_addr;
    logic [W-1:0] rd_data;

    logic         is_empty;
    logic         is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == D_CNT);

    // Index of the current top entry. Modulo-2**H arithmetic gives the right
    // slot when full (count = D wraps to 0, minus one gives D-1); the empty
    // case is masked on the top output and never used for a pop.
    assign top_addr = count_q[H-1:0] - 1'b1;

    stack_regfile #(
        .W (W),
        .H (H)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (top_addr),
        .rd_data (rd_data)
    );

    // -------------------------------------------------------------------------
    // Operation decode
    // -------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        // Clear first; an error event below re-sets the flag so set wins.
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        unf_d   = err_clr ? 1'b0 : unf_q;
        wr_en   = 1'b0;
        wr_addr = count_q[H-1:0];

        if (clear) begin
            // Flush: entries are abandoned, not erased.
            count_d = '0;
        end else begin
            case ({push, pop})
                OP_NOP: begin
                end
                OP_PUSH: begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!is_empty) begin
                        dout_d  = rd_data;
                        dv_d    = 1'b1;
                        count_d = count_q - 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                OP_RPL: begin
                    if (!is_empty) begin
                        // Replace: old top is returned and overwritten in
                        // the same edge; occupancy is unchanged.
                        dout_d  = rd_data;
                        dv_d    = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = top_addr;
                    end else begin
                        // Bypass: the pushed word goes straight out.
                        dout_d = data_in;
                        dv_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_out    = dout_q;
    assign dout_valid  = dv_q;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= AF_CNT);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    // Mask the array read when empty so stale or never-written entries
    // are not visible.
    assign top         = is_empty ? '0 : rd_data;

endmodule : lifo_stack_ctrl

// File: tb/tb_lifo_stack_ctrl.sv
module tb_lifo_stack_ctrl;

    localparam int W  = 8;
    localparam int H  = 3;
    localparam int AF = 7;

    logic         clk;
    logic         clear_n;
    logic         clear;
    logic         push;
    logic         pop;
    logic [W-1:0] data_in;
    logic         err_clr;
    logic [W-1:0] data_out;
    logic         dout_valid;
    logic [W-1:0] top;
    logic [H:0]   count;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         overflow;
    logic         underflow;

    lifo_stack_ctrl #(
        .W        (W),
        .H        (H),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .dout_valid  (dout_valid),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic       eclr;
        logic [7:0] din;
        logic [3:0] e_count;
        logic [7:0] e_top;
        logic [7:0] e_dout;
        logic       e_dv;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic clr, input logic psh, input logic pp, input logic eclr,
                       input logic [7:0] din, input logic [3:0] ec, input logic [7:0] et,
                       input logic [7:0] ed, input logic edv, input logic eo, input logic eu);
        vec_t v;
        v.clr = clr; v.psh = psh; v.pp = pp; v.eclr = eclr; v.din = din;
        v.e_count = ec; v.e_top = et; v.e_dout = ed; v.e_dv = edv;
        v.e_ovf = eo; v.e_unf = eu;
        vecs.push_back(v);
    endtask

    // Apply one set of inputs for one clock edge, then sample 1 ns later.
    task automatic step(input logic clr, input logic psh, input logic pp,
                        input logic eclr, input logic [7:0] din);
        clear = clr; push = psh; pop = pp; err_clr = eclr; data_in = din;
        @(posedge clk);
        #1;
        clear = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
        err_clr = 1'b0; data_in = '0;

        // ---------------- vector table ----------------
        // push 0x11..0x18
        for (int i = 1; i <= 8; i++)
            add(0, 1, 0, 0, 8'(8'h10 + i), 4'(i), 8'(8'h10 + i), 8'h00, 0, 0, 0);
        // full push -> overflow, then err_clr
        add(0, 1, 0, 0, 8'hAA, 4'd8, 8'h18, 8'h00, 0, 1, 0);
        add(0, 0, 0, 1, 8'h00, 4'd8, 8'h18, 8'h00, 0, 0, 0);
        // eight pops: 0x18..0x11
        for (int i = 7; i >= 0; i--)
            add(0, 0, 1, 0, 8'h00, 4'(i), (i == 0) ? 8'h00 : 8'(8'h10 + i),
                8'(8'h11 + i), 1, 0, 0);
        // ninth pop -> underflow, data_out held
        add(0, 0, 1, 0, 8'h00, 4'd0, 8'h00, 8'h11, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 4'd0, 8'h00, 8'h11, 0, 0, 0);
        // push 0x33, replace with 0x44, pop, bypass 0x55
        add(0, 1, 0, 0, 8'h33, 4'd1, 8'h33, 8'h11, 0, 0, 0);
        add(0, 1, 1, 0, 8'h44, 4'd1, 8'h44, 8'h33, 1, 0, 0);
        add(0, 0, 1, 0, 8'h00, 4'd0, 8'h00, 8'h44, 1, 0, 0);
        add(0, 1, 1, 0, 8'h55, 4'd0, 8'h00, 8'h55, 1, 0, 0);
        // push three, then clear together with push
        add(0, 1, 0, 0, 8'h01, 4'd1, 8'h01, 8'h55, 0, 0, 0);
        add(0, 1, 0, 0, 8'h02, 4'd2, 8'h02, 8'h55, 0, 0, 0);
        add(0, 1, 0, 0, 8'h03, 4'd3, 8'h03, 8'h55, 0, 0, 0);
        add(1, 1, 0, 0, 8'h77, 4'd0, 8'h00, 8'h55, 0, 0, 0);
        // pop on empty with err_clr in the same cycle -> set wins
        add(0, 0, 1, 1, 8'h00, 4'd0, 8'h00, 8'h55, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 4'd0, 8'h00, 8'h55, 0, 0, 0);

        // ---------------- reset state ----------------
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout",  32'(data_out), 32'd0);
        check("rst_dv",    32'(dout_valid), 32'd0);
        check("rst_top",   32'(top), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_flags", 32'({overflow, underflow, full}), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // ---------------- table-driven run ----------------
        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].eclr, vecs[i].din);
            $display("[TB] vec %0d clr=%0b push=%0b pop=%0b eclr=%0b din=%02h -> count=%0d top=%02h dout=%02h dv=%0b ovf=%0b unf=%0b",
                     i, vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].eclr, vecs[i].din,
                     count, top, data_out, dout_valid, overflow, underflow);
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("v%0d_top", i),   32'(top),   32'(vecs[i].e_top));
            check($sformatf("v%0d_dout", i),  32'(data_out), 32'(vecs[i].e_dout));
            check($sformatf("v%0d_dv", i),    32'(dout_valid), 32'(vecs[i].e_dv));
            check($sformatf("v%0d_ovf", i),   32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_unf", i),   32'(underflow), 32'(vecs[i].e_unf));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_count == 0));
            check($sformatf("v%0d_full", i),  32'(full),  32'(vecs[i].e_count == 8));
            check($sformatf("v%0d_af", i),    32'(almost_full), 32'(vecs[i].e_count >= AF));
        end

        // ---------------- async reset mid-burst ----------------
        step(0, 1, 0, 0, 8'h99);
        step(0, 1, 0, 0, 8'h9A);
        step(0, 0, 1, 0, 8'h00);
        $display("[TB] burst pop -> count=%0d dout=%02h dv=%0b", count, data_out, dout_valid);
        check("burst_dout", 32'(data_out), 32'h9A);
        check("burst_dv",   32'(dout_valid), 32'd1);
        #2;
        clear_n = 1'b0;
        #1;
        $display("[TB] async reset -> count=%0d dout=%02h dv=%0b top=%02h", count, data_out, dout_valid, top);
        check("arst_count", 32'(count), 32'd0);
        check("arst_dout",  32'(data_out), 32'd0);
        check("arst_dv",    32'(dout_valid), 32'd0);
        check("arst_top",   32'(top), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        clear_n = 1'b1;
        step(0, 1, 0, 0, 8'h5A);
        $display("[TB] push after reset -> count=%0d top=%02h", count, top);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_top",   32'(top), 32'h5A);
        step(0, 0, 1, 0, 8'h00);
        $display("[TB] pop after reset -> dout=%02h dv=%0b", data_out, dout_valid);
        check("post_rst_dout", 32'(data_out), 32'h5A);
        check("post_rst_dv",   32'(dout_valid), 32'd1);
        step(0, 0, 0, 0, 8'h00);
        check("dv_pulse_drop", 32'(dout_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lifo_stack_ctrl

// File: doc/lifo_stack_ctrl.md
Name: lifo_stack_ctrl

Overview:
- Parametrised synchronous LIFO stack used by the CPU datapath to save and restore context words. Grows upward.
- Successor to the fixed 8x8 stack. Adds:
  - parameterised depth and width
  - separate push and pop strobes, with simultaneous push+pop as replace/bypass
  - an occupancy count and an almost-full flag
  - sticky overflow/underflow errors
  - a registered pop output with a valid strobe
  - a combinational peek of the top of stack

Parameters:
- W, 8, data word width in bits.
- H, 3, log2 of depth. Depth D = 2**H entries.
- AF_LEVEL, 2**H-1, occupancy at or above which almost_full asserts. Legal range 1..D.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush. Has priority over push/pop.
- push  in  1  push data_in this cycle.
- pop  in  1  pop top of stack this cycle.
- data_in  in  W  word to push.
- err_clr  in  1  synchronous clear of the sticky error flags.
- data_out  out  W  registered popped word. Holds its value until the next successful pop.
- dout_valid  out  1  one-cycle pulse the cycle after a successful pop.
- top  out  W  combinational mem[count-1]. Value is 0 when empty.
- count  out  H+1  number of stored entries, 0..D.
- empty  out  1  count == 0, combinational from count.
- full  out  1  count == D.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky. Set by a push-only attempt while full.
- underflow  out  1  sticky. Set by a pop-only attempt while empty.

Behaviour:
- Async reset (clear_n = 0), taking effect immediately:
  - count = 0, data_out = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset. top reads 0 because empty.
- Sync clear = 1: count = 0, dout_valid = 0 next cycle. data_out and error flags are held. push/pop are ignored that cycle.
- Per-cycle operation (clear = 0), decoded from {push, pop}:
  - 00 NOP: state held, dout_valid = 0.
  - 10 PUSH, not full: mem[count] = data_in, count + 1.
  - 10 PUSH, full: memory and count unchanged, overflow set.
  - 01 POP, not empty: data_out = mem[count-1], dout_valid = 1, count - 1.
  - 01 POP, empty: no change, dout_valid = 0, underflow set.
  - 11 REPLACE, not empty: data_out = mem[count-1], mem[count-1] = data_in, dout_valid = 1, count unchanged. Legal when full; no overflow.
  - 11 BYPASS, empty: data_out = data_in, dout_valid = 1, count stays 0. No underflow.
- Pop latency: 1 cycle. Data is visible on data_out together with dout_valid on the cycle after the pop strobe.
- top reflects the post-edge state combinationally. No read-during-write hazard exists: the write address and top address differ except on REPLACE, where top shows the new word after the edge.
- Counter never wraps. count saturates logically at 0 and D by the guards above. Width is H+1 so that D is representable.
- err_clr clears both sticky flags. If an error event occurs in the same cycle, the flag is set (set wins).
- Reset mid-operation: asynchronous assertion aborts any pending update. The first edge after release behaves as from empty.
- No internal FSM beyond the count register. The operation decode is a 2-bit one-hot-free case on {push, pop}.

Decomposition:
- Shared package stack_pkg:
  - op encoding constants OP_NOP = 2'b00, OP_PUSH = 2'b10, OP_POP = 2'b01, OP_RPL = 2'b11.
  - Helper function depth(H) = 2**H.
- One sub-module, stack_regfile: W x D register array with one synchronous write port and one asynchronous read port (address, data). No reset on the array.
- lifo_stack_ctrl holds count, flags, data_out and the operation decode.

Test Plan (W = 8, H = 3, AF_LEVEL = 7):
- Reset then push 0x11..0x18 over 8 cycles -> count 1..8. almost_full rises at count = 7, full at 8. top = 0x18, overflow = 0.
- Full stack, push 0xAA alone -> count stays 8, top = 0x18, overflow = 1. Then err_clr -> overflow = 0.
- Full stack, 8 consecutive pops -> data_out sequence 0x18..0x11, each with dout_valid one cycle after its pop. Ends empty = 1, top = 0. Ninth pop -> dout_valid = 0, underflow = 1, data_out stays 0x11.
- Push 0x33, then push+pop with data_in 0x44 -> data_out = 0x33, dout_valid = 1, count = 1, top = 0x44. On empty, push+pop with 0x55 -> data_out = 0x55, count = 0, no error flags.
- Push 3 words, assert clear together with push -> count = 0, empty = 1, nothing written. Also assert clear_n low mid-burst -> outputs zero immediately, before the next clock edge.
- Pop on empty and err_clr in the same cycle -> underflow = 1 (set wins).
